// File: rtl/mdu_hilo.sv
// ============================================================================
// Module   : mdu_hilo
// Purpose  : Iterative multiply/divide unit with HI/LO result registers.
//            Shift-add multiply, restoring divide, one 33-bit add per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] C_LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]       r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_b_zero;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hp;     // partial HI (multiply) / remainder (divide)
    logic [WIDTH-1:0] r_lp;     // multiplier (multiply) / quotient (divide)
    logic [WIDTH-1:0] r_opnd;   // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    logic             w_start_ok;
    logic             w_is_div;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_add_x;
    logic [WIDTH:0]   w_add_y;
    logic             w_cin;
    logic [WIDTH+1:0] w_sum;
    logic             w_no_borrow;
    logic [WIDTH-1:0] w_hp_nxt;
    logic [WIDTH-1:0] w_lp_nxt;
    logic             w_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_f;
    logic [WIDTH-1:0] w_quot_f;
    logic [WIDTH-1:0] w_rem_f;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_is_div   = r_op[1];

    // Unsigned ops take raw operands; 0x80000000 negates to itself, read as unsigned.
    assign w_sign_a = op[0] & a[WIDTH-1];
    assign w_sign_b = op[0] & b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? (~a + 1'b1) : a;
    assign w_mag_b  = w_sign_b ? (~b + 1'b1) : b;

    // Shared adder: multiply adds the multiplicand, divide subtracts the divisor.
    always_comb begin
        w_add_x = '0;
        w_add_y = '0;
        w_cin   = 1'b0;
        if (w_is_div) begin
            w_add_x = {r_hp, r_lp[WIDTH-1]};
            w_add_y = ~{1'b0, r_opnd};
            w_cin   = 1'b1;
        end else begin
            w_add_x = {1'b0, r_hp};
            w_add_y = r_lp[0] ? {1'b0, r_opnd} : '0;
        end
    end

    assign w_sum       = {1'b0, w_add_x} + {1'b0, w_add_y} + {{(WIDTH+1){1'b0}}, w_cin};
    assign w_no_borrow = w_sum[WIDTH+1];

    always_comb begin
        w_hp_nxt = '0;
        w_lp_nxt = '0;
        if (w_is_div) begin
            w_hp_nxt = w_no_borrow ? w_sum[WIDTH-1:0] : w_add_x[WIDTH-1:0];
            w_lp_nxt = {r_lp[WIDTH-2:0], w_no_borrow};
        end else begin
            w_hp_nxt = w_sum[WIDTH:1];
            w_lp_nxt = {w_sum[0], r_lp[WIDTH-1:1]};
        end
    end

    assign w_neg    = r_sign_a ^ r_sign_b;
    assign w_prod   = {r_hp, r_lp};
    assign w_prod_f = w_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_quot_f = w_neg ? (~r_lp + 1'b1) : r_lp;
    // With a zero divisor every trial succeeds, so the remainder ends as |a|
    // and the sign fix-up below restores the raw dividend for HI.
    assign w_rem_f  = r_sign_a ? (~r_hp + 1'b1) : r_hp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == C_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_b_zero   <= 1'b0;
            r_cnt      <= '0;
            r_hp       <= '0;
            r_lp       <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_op       <= op;
                        r_sign_a   <= w_sign_a;
                        r_sign_b   <= w_sign_b;
                        r_b_zero   <= (b == '0);
                        r_cnt      <= '0;
                        r_hp       <= '0;
                        r_div_zero <= 1'b0;
                        if (op[1]) begin
                            r_lp   <= w_mag_a;
                            r_opnd <= w_mag_b;
                        end else begin
                            r_lp   <= w_mag_b;
                            r_opnd <= w_mag_a;
                        end
                    end else begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_CALC: begin
                    r_hp  <= w_hp_nxt;
                    r_lp  <= w_lp_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (w_is_div) begin
                        r_hi       <= w_rem_f;
                        r_lo       <= r_b_zero ? '1 : w_quot_f;
                        r_div_zero <= r_b_zero;
                    end else begin
                        r_hi <= w_prod_f[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_f[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ============================================================================
// Module   : tb_mdu_hilo
// Purpose  : Directed self-checking bench for mdu_hilo.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_hilo;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] C_MULTU = 2'b00;
    localparam logic [1:0] C_MULT  = 2'b01;
    localparam logic [1:0] C_DIVU  = 2'b10;
    localparam logic [1:0] C_DIV   = 2'b11;

    mdu_hilo #(.WIDTH(32), .ITER(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Start edge is T0; returns 1 ns after it with operands scrambled.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'hA5A5_5A5A;
        b = 32'h0F0F_F0F0;
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        while (!done && lat < 50) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int lat, nb;
        launch(o, x, y);
        wait_done(lat, nb);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    endtask

    initial begin
        int lat, nb, ndone;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz",   64'(div_zero), 64'd0);
        check("rst_hi",   64'(hi), 64'd0);
        check("rst_lo",   64'(lo), 64'd0);
        rst_n = 1'b1;

        launch(C_MULTU, 32'd7, 32'd6);
        wait_done(lat, nb);
        check("multu7x6_lat",  64'(lat), 64'd33);
        check("multu7x6_busy", 64'(nb), 64'd33);
        check("multu7x6_hi",   64'(hi), 64'h0);
        check("multu7x6_lo",   64'(lo), 64'h2A);

        run_op("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m3x5", C_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("divu_100_7", C_DIVU, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0);
        run_op("div_m7_2",  C_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf",   C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0);
        run_op("divu_zero", C_DIVU,  32'h0000_1234, 32'h0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1);

        // Next start clears div_zero; mid-flight start and mthi are ignored.
        launch(C_MULTU, 32'd3, 32'd4);
        check("dz_clear", 64'(div_zero), 64'd0);
        check("busy_t0",  64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        start = 1'b1; op = C_DIVU; a = 32'd99; b = 32'd5; mthi = 1'b1; wdata = 32'h1111_2222;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("hi_hold_busy", 64'(hi), 64'h0000_1234);
        wait_done(lat, nb);
        check("ignore_hi", 64'(hi), 64'h0);
        check("ignore_lo", 64'(lo), 64'd12);
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("done_pulse", 64'(done), 64'd0);
        check("mtlo_lo", 64'(lo), 64'hDEAD_BEEF);
        check("mtlo_hi", 64'(hi), 64'h0);

        // mthi+mtlo together, then reset mid-divide.
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("both_hi", 64'(hi), 64'h55);
        check("both_lo", 64'(lo), 64'h55);
        launch(C_DIVU, 32'd1000, 32'd3);
        repeat (20) @(negedge clk);
        check("busy_mid", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi",   64'(hi), 64'h0);
        check("arst_lo",   64'(lo), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_nodone", 64'(ndone), 64'd0);
        check("arst_idle",   64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with HI/LO result registers for the MIPS core. It sits directly downstream of the ALU operand path.
- It consumes the same rs/rt 32-bit operands as the adder/subtractor stage. Each cycle it performs one 33-bit add/subtract step.
- It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and exposes HI/LO for MFHI/MFLO.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- ITER, 32, number of iteration cycles; must equal WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only when busy=0
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  32  multiplicand / dividend (rs)
- b  in  32  multiplier / divisor (rt)
- mthi  in  1  write wdata to HI (used when idle)
- mtlo  in  1  write wdata to LO (used when idle)
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- div_zero  out  1  last completed DIV/DIVU had b==0; holds until the next accepted start
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, internal registers 0. Reset asserted mid-operation aborts the operation; no HI/LO update occurs.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 at edge T0 latches op, the sign flags of a and b, and |a|, |b|.
  - Magnitudes are used for signed ops; raw values are used for unsigned ops. |0x80000000| = 0x80000000, treated as unsigned.
  - On the same edge: counter=0, busy=1, div_zero cleared, go to CALC.
- CALC, edges T0+1..T0+32 (counter 0..31):
  - Multiply: shift-add. If the multiplier LSB is 1, the 33-bit sum of partial HI and the multiplicand is taken. The {carry, partial HI, multiplier} register then shifts right 1.
  - Divide: restoring. Shift {rem, quot} left 1, then trial = rem - divisor, a 33-bit subtract done as rem + ~divisor + 1. If there is no borrow, rem=trial and quot LSB=1; otherwise quot LSB=0.
  - Counter increments each edge. After counter==31 is processed, go to FIX.
- FIX, edge T0+33:
  - MULT: if sign(a)!=sign(b), negate the 64-bit product. hi=product[63:32], lo=product[31:0].
  - DIV: if sign(a)!=sign(b), negate the quotient. The remainder takes the sign of a. lo=quotient, hi=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 with no error.
  - Divide by zero (b==0 at start, either divide op): lo=0xFFFFFFFF, hi=a as latched raw, div_zero=1.
  - Same edge: done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: start sampled at T0 -> done high during the cycle after edge T0+33, which is 33 cycles.
- Throughput: a new start is accepted on the edge where done is high, because busy=0 in that cycle.
- start while busy=1: ignored; the in-flight operation and latched operands are unaffected.
- mthi/mtlo:
  - Honoured only when busy=0 and start=0; the write lands on that edge.
  - Ignored while busy=1.
  - start and mthi/mtlo asserted together: start wins and the write is dropped.
  - mthi and mtlo together: both written with wdata.
- hi/lo hold their values outside FIX and mthi/mtlo writes. MFHI during busy is the stall logic's responsibility; the block outputs the old value.
- Operands a and b may change after the start edge without effect.

Test Plan:
- MULTU a=7, b=6 -> done 33 cycles after start; hi=0x00000000, lo=0x0000002A; busy high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234, div_zero=1. Next start clears div_zero at the start edge.
- Start MULTU 3*4, then pulse start with other operands and mthi at cycle 10 -> both ignored; result lo=12. After done, mtlo wdata=0xDEADBEEF -> lo=0xDEADBEEF on the next edge.
- Reset at cycle 20 of DIVU with hi=lo=0x55 preloaded -> busy=0, hi=lo=0 immediately (asynchronous), and no done pulse.
